regfile_bus_sequencer: RTL and testbench



---
 rtl/regfile_pkg.sv | 35 +++
 rtl/regfile_bus_sequencer_if.sv | 17 +
 rtl/regfile_bus_sequencer.sv | 164 ++++++++++++++++
 tb/tb_regfile_bus_sequencer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Argon register file shared types: index/word widths, bus command codes, request opcodes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package regfile_pkg;

    localparam int INDEX_WIDTH = 3;
    localparam int WORD_WIDTH  = 16;

    typedef logic [INDEX_WIDTH-1:0] index_t;
    typedef logic [WORD_WIDTH-1:0]  word_t;

    // Argon bus command codes understood by the register file.
    typedef logic [2:0] com_t;
    localparam com_t COM_NOP      = 3'd0;
    localparam com_t COM_LATCHSEL = 3'd1;
    localparam com_t COM_ALU_WE   = 3'd2;
    localparam com_t COM_LATCHC   = 3'd3;
    localparam com_t COM_READA    = 3'd4;
    localparam com_t COM_READB    = 3'd5;
    localparam com_t COM_READF    = 3'd6;

    // Register-level operations requested by the control path.
    typedef enum logic [2:0] {
        OP_ALU   = 3'd0,
        OP_LOADI = 3'd1,
        OP_READA = 3'd2,
        OP_READB = 3'd3,
        OP_READF = 3'd4
    } op_t;

    function automatic logic is_read(op_t op);
        return (op == OP_READA) || (op == OP_READB) || (op == OP_READF);
    endfunction

endpackage

// File: rtl/regfile_bus_sequencer_if.sv
// Argon register file bus: initiator drives command/i_data/i_valid, register file returns o_data/o_valid.
// Latency: o_data/o_valid answer combinationally in the cycle a READ command is on the bus.
// Backpressure: none; o_valid=0 during a read marks the returned data as bad.
interface regfile_bus_sequencer_if;
    import regfile_pkg::*;

    com_t  command;
    word_t i_data;
    logic  i_valid;
    word_t o_data;
    logic  o_valid;

    modport master (output command, output i_data, output i_valid,
                    input  o_data,  input  o_valid);
    modport slave  (input  command, input  i_data, input  i_valid,
                    output o_data,  output o_valid);
endinterface

// File: rtl/regfile_bus_sequencer.sv
// Expands one register-level request (ALU writeback, load-immediate, read A/B/F) into Argon bus commands.
// Latency: accept cycle to o_rsp_valid is 3 cycles (+ALU_LATENCY for OP_ALU), one less when LATCHSEL is skipped.
// Backpressure: o_req_ready only in IDLE; one request in flight, response is a one-cycle pulse with no ready.
//
// Ports: i_Clk, i_Reset (sync, active high); bus_if (initiator modport, registered outputs);
//        i_req_valid/o_req_ready with i_op, i_sel_a/b/c, i_imm; o_rsp_valid/o_rsp_data/o_rsp_error.
module regfile_bus_sequencer
    import regfile_pkg::*;
#(
    parameter int unsigned ALU_LATENCY = 1,
    parameter bit          SKIP_SEL    = 1'b1
) (
    input  logic                           i_Clk,
    input  logic                           i_Reset,
    regfile_bus_sequencer_if.master        bus_if,
    input  logic                           i_req_valid,
    output logic                           o_req_ready,
    input  op_t                            i_op,
    input  index_t                         i_sel_a,
    input  index_t                         i_sel_b,
    input  index_t                         i_sel_c,
    input  word_t                          i_imm,
    output logic                           o_rsp_valid,
    output word_t                          o_rsp_data,
    output logic                           o_rsp_error
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SEL  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_EXEC = 3'd3;
    localparam logic [2:0] S_RESP = 3'd4;

    localparam int SEL_BITS = 3 * INDEX_WIDTH;

    // WAIT is entered with the count already covering its first cycle.
    localparam logic [3:0] WAIT_INIT = (ALU_LATENCY == 0) ? 4'd0 : 4'(ALU_LATENCY - 1);

    logic [2:0]          state, nxt_state;
    op_t                 op_q;
    logic [SEL_BITS-1:0] sel_q;
    word_t               imm_q;
    logic [SEL_BITS-1:0] cache_sel;
    logic                cache_vld;
    logic [3:0]          wait_cnt;

    logic                accept;
    op_t                 op_in;
    logic [SEL_BITS-1:0] sel_in;
    logic                sel_hit;
    op_t                 op_n;
    logic [SEL_BITS-1:0] sel_n;
    word_t               imm_n;
    com_t                cmd_n;
    logic                ivld_n;
    word_t               idat_n;

    function automatic logic [2:0] after_sel(op_t op);
        return (op == OP_ALU && ALU_LATENCY != 0) ? S_WAIT : S_EXEC;
    endfunction

    assign o_req_ready = (state == S_IDLE);
    assign accept      = i_req_valid && o_req_ready;
    // Opcodes outside the defined set behave as a flags read.
    assign op_in       = (i_op > OP_READF) ? OP_READF : i_op;
    assign sel_in      = {i_sel_c, i_sel_b, i_sel_a};
    assign sel_hit     = SKIP_SEL && cache_vld && (sel_in == cache_sel);

    // The first bus cycle is launched from IDLE, before the request is in the capture registers.
    assign op_n  = (state == S_IDLE) ? op_in  : op_q;
    assign sel_n = (state == S_IDLE) ? sel_in : sel_q;
    assign imm_n = (state == S_IDLE) ? i_imm  : imm_q;

    always_comb begin
        nxt_state = state;
        case (state)
            S_IDLE:  if (accept) nxt_state = sel_hit ? after_sel(op_in) : S_SEL;
            S_SEL:   nxt_state = after_sel(op_q);
            S_WAIT:  if (wait_cnt == 4'd0) nxt_state = S_EXEC;
            S_EXEC:  nxt_state = S_RESP;
            S_RESP:  nxt_state = S_IDLE;
            default: nxt_state = S_IDLE;
        endcase
    end

    // Bus outputs are registered, so they are decoded from the state being entered.
    always_comb begin
        cmd_n  = COM_NOP;
        ivld_n = 1'b0;
        idat_n = '0;
        case (nxt_state)
            S_SEL: begin
                cmd_n                  = COM_LATCHSEL;
                ivld_n                 = 1'b1;
                idat_n[SEL_BITS-1:0]   = sel_n;
            end
            S_EXEC: begin
                case (op_n)
                    OP_ALU:   cmd_n = COM_ALU_WE;
                    OP_LOADI: begin
                        cmd_n  = COM_LATCHC;
                        ivld_n = 1'b1;
                        idat_n = imm_n;
                    end
                    OP_READA: cmd_n = COM_READA;
                    OP_READB: cmd_n = COM_READB;
                    default:  cmd_n = COM_READF;
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state          <= S_IDLE;
            op_q           <= OP_ALU;
            sel_q          <= '0;
            imm_q          <= '0;
            cache_sel      <= '0;
            cache_vld      <= 1'b0;
            wait_cnt       <= 4'd0;
            bus_if.command <= COM_NOP;
            bus_if.i_valid <= 1'b0;
            bus_if.i_data  <= '0;
            o_rsp_valid    <= 1'b0;
            o_rsp_data     <= '0;
            o_rsp_error    <= 1'b0;
        end else begin
            state          <= nxt_state;
            bus_if.command <= cmd_n;
            bus_if.i_valid <= ivld_n;
            bus_if.i_data  <= idat_n;
            o_rsp_valid    <= (nxt_state == S_RESP);

            if (accept) begin
                op_q  <= op_in;
                sel_q <= sel_in;
                imm_q <= i_imm;
                if (!is_read(op_in)) begin
                    o_rsp_data  <= '0;
                    o_rsp_error <= 1'b0;
                end
            end

            if (state == S_SEL) begin
                cache_sel <= sel_q;
                cache_vld <= 1'b1;
            end

            if (nxt_state == S_WAIT && state != S_WAIT)
                wait_cnt <= WAIT_INIT;
            else if (state == S_WAIT && wait_cnt != 4'd0)
                wait_cnt <= wait_cnt - 4'd1;

            // The read command occupies the EXEC bus cycle; sample the answer as it ends.
            if (state == S_EXEC && is_read(op_q)) begin
                o_rsp_data  <= bus_if.o_data;
                o_rsp_error <= !bus_if.o_valid;
            end
        end
    end

endmodule

// File: tb/tb_regfile_bus_sequencer.sv
`timescale 1ns/1ps
module tb_regfile_bus_sequencer;
    import regfile_pkg::*;

    localparam int L0 = 3;   // ALU_LATENCY of instance 0; instance 1 uses 0

    logic i_Clk = 1'b0;
    logic i_Reset;
    always #5 i_Clk = ~i_Clk;

    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [1:0] rsp_valid;
    logic [1:0] rsp_error;
    word_t      rsp_data0, rsp_data1;
    op_t        req_op;
    index_t     sa, sb, sc;
    word_t      imm;

    regfile_bus_sequencer_if b0();
    regfile_bus_sequencer_if b1();

    regfile_bus_sequencer #(.ALU_LATENCY(L0), .SKIP_SEL(1'b1)) dut (
        .i_Clk(i_Clk), .i_Reset(i_Reset), .bus_if(b0),
        .i_req_valid(req_valid[0]), .o_req_ready(req_ready[0]),
        .i_op(req_op), .i_sel_a(sa), .i_sel_b(sb), .i_sel_c(sc), .i_imm(imm),
        .o_rsp_valid(rsp_valid[0]), .o_rsp_data(rsp_data0), .o_rsp_error(rsp_error[0])
    );

    regfile_bus_sequencer #(.ALU_LATENCY(0), .SKIP_SEL(1'b0)) dut_ns (
        .i_Clk(i_Clk), .i_Reset(i_Reset), .bus_if(b1),
        .i_req_valid(req_valid[1]), .o_req_ready(req_ready[1]),
        .i_op(req_op), .i_sel_a(sa), .i_sel_b(sb), .i_sel_c(sc), .i_imm(imm),
        .o_rsp_valid(rsp_valid[1]), .o_rsp_data(rsp_data1), .o_rsp_error(rsp_error[1])
    );

    function automatic word_t flags_of(input word_t s);
        return {s[15:8], 7'b0, (s == 16'h0000)};
    endfunction

    // Register file model behind instance 0.
    word_t  rf [8] = '{default: '0};
    index_t m_a = '0, m_b = '0, m_c = '0;
    word_t  m_flags = '0;
    logic   force_inv;

    always @(posedge i_Clk) begin
        case (b0.command)
            COM_LATCHSEL: begin
                m_a <= b0.i_data[2:0];
                m_b <= b0.i_data[5:3];
                m_c <= b0.i_data[8:6];
            end
            COM_LATCHC: if (m_c != 0) rf[m_c] <= b0.i_data;
            COM_ALU_WE: begin
                if (m_c != 0) rf[m_c] <= rf[m_a] + rf[m_b];
                m_flags <= flags_of(rf[m_a] + rf[m_b]);
            end
            default: ;
        endcase
    end

    always_comb begin
        b0.o_data = '0;
        case (b0.command)
            COM_READA: b0.o_data = rf[m_a];
            COM_READB: b0.o_data = rf[m_b];
            COM_READF: b0.o_data = m_flags;
            default: ;
        endcase
        b0.o_valid = !force_inv;
    end

    // Instance 1 only needs a constant responder.
    assign b1.o_data  = 16'h1234;
    assign b1.o_valid = 1'b1;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    typedef struct {
        int    k;
        int    lat;
        logic  sel;
        word_t data;
        logic  err;
    } exp_t;

    exp_t sbq[$];

    // Architectural shadow of the register file and the sequencer's select cache.
    word_t      sh [8] = '{default: '0};
    word_t      sh_flags = '0;
    logic [8:0] cache = '0;
    logic       cache_v = 1'b0;

    // Monitor: cycle count since accept, LATCHSEL seen, last bus payloads, scoreboard pop.
    int    cnt [2] = '{0, 0};
    logic  seen [2] = '{1'b0, 1'b0};
    word_t last_sel = '0, last_c = '0;
    exp_t  mon_e;
    com_t  mcmd;
    word_t mdat;

    always @(negedge i_Clk) begin
        for (int k = 0; k < 2; k++) begin
            mcmd = (k == 0) ? b0.command : b1.command;
            mdat = (k == 0) ? rsp_data0 : rsp_data1;
            if (req_valid[k] && req_ready[k]) begin
                cnt[k]  = 0;
                seen[k] = 1'b0;
            end else begin
                cnt[k]++;
            end
            if (mcmd == COM_LATCHSEL) begin
                seen[k] = 1'b1;
                if (k == 0) last_sel = b0.i_data;
            end
            if (k == 0 && mcmd == COM_LATCHC) last_c = b0.i_data;
            if (rsp_valid[k]) begin
                if (sbq.size() == 0) begin
                    chk("spurious_rsp", 32'd1, 32'd0);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("rsp_inst",       k,         mon_e.k);
                    chk("rsp_latency",    cnt[k],    mon_e.lat);
                    chk("rsp_sel_issued", seen[k],   mon_e.sel);
                    chk("rsp_data",       mdat,      mon_e.data);
                    chk("rsp_error",      rsp_error[k], mon_e.err);
                end
            end
        end
    end

    task automatic do_req(input int k, input logic [2:0] opc,
                          input index_t a, input index_t b, input index_t c, input word_t im);
        exp_t       e;
        logic [2:0] eop;
        logic       hit;
        logic       acc;
        word_t      sum;
        eop    = (opc > 3'd4) ? 3'd4 : opc;
        hit    = (k == 0) && cache_v && ({c, b, a} == cache);
        e.k    = k;
        e.sel  = !hit;
        e.lat  = (hit ? 2 : 3) + ((eop == 3'd0 && k == 0) ? L0 : 0);
        e.data = '0;
        e.err  = 1'b0;
        if (k == 1) begin
            if (eop >= 3'd2) e.data = 16'h1234;
        end else begin
            case (eop)
                3'd0: begin
                    sum = sh[a] + sh[b];
                    if (c != 0) sh[c] = sum;
                    sh_flags = flags_of(sum);
                end
                3'd1: if (c != 0) sh[c] = im;
                3'd2: begin e.data = sh[a];    e.err = force_inv; end
                3'd3: begin e.data = sh[b];    e.err = force_inv; end
                default: begin e.data = sh_flags; e.err = force_inv; end
            endcase
            cache   = {c, b, a};
            cache_v = 1'b1;
        end
        sbq.push_back(e);

        @(posedge i_Clk); #1;
        req_op = op_t'(opc);
        sa = a; sb = b; sc = c; imm = im;
        req_valid[k] = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge i_Clk);
            if (req_ready[k]) acc = 1'b1;
            @(posedge i_Clk); #1;
        end
        req_valid[k] = 1'b0;
        if (!acc) begin
            chk("accept_timeout", 32'd0, 32'd1);
            sbq.delete();
            return;
        end
        for (int i = 0; i < 50 && sbq.size() != 0; i++) begin
            @(negedge i_Clk); #1;
        end
        if (sbq.size() != 0) begin
            chk("rsp_timeout", sbq.size(), 32'd0);
            sbq.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        i_Reset   = 1'b1;
        req_valid = 2'b00;
        req_op    = OP_ALU;
        sa = '0; sb = '0; sc = '0; imm = '0;
        force_inv = 1'b0;
        repeat (3) @(posedge i_Clk);
        #1 i_Reset = 1'b0;

        chk("rst_ready",    req_ready[0], 1);
        chk("rst_rsp_vld",  rsp_valid[0], 0);
        chk("rst_rsp_data", rsp_data0,    0);
        chk("rst_rsp_err",  rsp_error[0], 0);
        chk("rst_command",  b0.command,   COM_NOP);
        chk("rst_i_valid",  b0.i_valid,   0);
        chk("rst_i_data",   b0.i_data,    0);

        do_req(0, 3'd1, 3'd0, 3'd0, 3'd2, 16'hBEEF);      // LOADI r2
        chk("latchsel_c_field", last_sel[8:6], 2);
        chk("latchc_data",      last_c,        16'hBEEF);
        do_req(0, 3'd2, 3'd2, 3'd0, 3'd2, 16'h0);         // READA r2
        do_req(0, 3'd3, 3'd2, 3'd2, 3'd0, 16'h0);         // READB r2
        do_req(0, 3'd3, 3'd2, 3'd2, 3'd0, 16'h0);         // same selects: SEL skipped
        do_req(0, 3'd1, 3'd0, 3'd0, 3'd1, 16'h0005);      // LOADI r1
        do_req(0, 3'd0, 3'd1, 3'd2, 3'd3, 16'h0);         // ALU r3 = r1 + r2
        do_req(0, 3'd2, 3'd3, 3'd0, 3'd0, 16'h0);         // READA r3
        force_inv = 1'b1;
        do_req(0, 3'd4, 3'd3, 3'd0, 3'd0, 16'h0);         // READF with bad o_valid
        force_inv = 1'b0;
        do_req(0, 3'd1, 3'd0, 3'd0, 3'd4, 16'h0001);      // LOADI clears error
        do_req(0, 3'd6, 3'd1, 3'd1, 3'd1, 16'h0);         // unknown op -> READF
        do_req(0, 3'd2, 3'd0, 3'd0, 3'd0, 16'h0);         // READA r0
        do_req(0, 3'd1, 3'd5, 3'd0, 3'd0, 16'hFFFF);      // LOADI to r0, suppressed
        do_req(0, 3'd2, 3'd0, 3'd0, 3'd5, 16'h0);         // r0 still zero

        // Reset while the ALU op sits in WAIT.
        @(posedge i_Clk); #1;
        req_op = OP_ALU; sa = 3'd1; sb = 3'd2; sc = 3'd3;
        req_valid[0] = 1'b1;
        @(negedge i_Clk);
        chk("rstw_ready_before", req_ready[0], 1);
        @(posedge i_Clk); #1;
        req_valid[0] = 1'b0;
        @(posedge i_Clk); #1;
        chk("rstw_wait_cmd", b0.command, COM_NOP);
        @(posedge i_Clk); #1;
        i_Reset = 1'b1;
        @(posedge i_Clk); #1;
        i_Reset = 1'b0;
        cache_v = 1'b0;
        chk("rstw_cmd",    b0.command,   COM_NOP);
        chk("rstw_ivalid", b0.i_valid,   0);
        chk("rstw_ready",  req_ready[0], 1);
        chk("rstw_rsp",    rsp_valid[0], 0);
        repeat (8) @(posedge i_Clk);
        do_req(0, 3'd2, 3'd1, 3'd2, 3'd3, 16'h0);         // same selects, cache must be cold

        // Instance without select skipping and zero ALU latency.
        do_req(1, 3'd3, 3'd1, 3'd1, 3'd1, 16'h0);
        do_req(1, 3'd3, 3'd1, 3'd1, 3'd1, 16'h0);
        do_req(1, 3'd0, 3'd1, 3'd2, 3'd3, 16'h0);

        repeat (4) @(posedge i_Clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
